pattern_tx: RTL and testbench



---
 rtl/pattern_tx_pkg.sv | 13 +
 rtl/pattern_tx_ctr.sv | 27 ++
 rtl/pattern_tx.sv | 142 ++++++++++++++
 tb/tb_pattern_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// Shared encodings for the serial pattern transmitter: FSM state values and default pattern.
package pattern_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_GAP  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   localparam logic [3:0] PATTERN_DEF = 4'b1011;

endpackage

// File: rtl/pattern_tx_ctr.sv
// Loadable saturating down-counter with zero flag; used for repetitions and gap length.
module pattern_tx_ctr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: bursts of PATTERN (MSB first) with idle gaps and start/busy/done.
// Optional abort input enabled by defining PATTERN_TX_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// SEND  | shifting out pattern bit r_idx, valid high
// GAP   | inserting zeros between repetitions
// DONE  | one-cycle done pulse, then IDLE
module pattern_tx
   import pattern_tx_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
   parameter int               CNT_W   = 8,
   parameter int               GAP_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [GAP_W-1:0] gap,
   output logic             x_out,
   output logic             valid,
   output logic             busy,
   output logic             done
`ifdef PATTERN_TX_ABORT_EN
   ,
   input  logic             abort
`endif
);

   localparam int                IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PAT_W - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [GAP_W-1:0]   r_gap_len;
   logic               r_x_out, r_valid, r_busy, r_done;
   logic               w_x_nxt;
   logic               w_accept;
   logic               w_rep_load, w_rep_dec, w_rep_zero;
   logic               w_gap_load, w_gap_dec, w_gap_zero;

   // Counters hold "remaining minus one" so the zero flag alone marks the last repetition/gap cycle.
   pattern_tx_ctr #(.W(CNT_W)) u_rep_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_rep_load),
      .i_load_val (count - CNT_W'(1)),
      .i_dec      (w_rep_dec),
      .o_zero     (w_rep_zero)
   );

   pattern_tx_ctr #(.W(GAP_W)) u_gap_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_gap_load),
      .i_load_val (r_gap_len - GAP_W'(1)),
      .i_dec      (w_gap_dec),
      .o_zero     (w_gap_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_gap_len <= '0;
         r_x_out   <= 1'b0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_accept) r_gap_len <= gap;
         r_x_out <= w_x_nxt;
         r_valid <= (w_state_nxt == ST_SEND);
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_accept    = 1'b0;
      w_rep_load  = 1'b0;
      w_rep_dec   = 1'b0;
      w_gap_load  = 1'b0;
      w_gap_dec   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_rep_load  = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = (count != '0) ? ST_SEND : ST_DONE;
            end
         end
         ST_SEND: begin
            if (r_idx == IDX_LAST) begin
               w_idx_nxt = '0;
               if (w_rep_zero) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_rep_dec = 1'b1;
                  if (r_gap_len != '0) begin
                     w_state_nxt = ST_GAP;
                     w_gap_load  = 1'b1;
                  end
               end
            end else begin
               w_idx_nxt = r_idx + IDX_W'(1);
            end
         end
         ST_GAP: begin
            if (w_gap_zero) w_state_nxt = ST_SEND;
            else            w_gap_dec   = 1'b1;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
`ifdef PATTERN_TX_ABORT_EN
      if (abort && ((r_state == ST_SEND) || (r_state == ST_GAP))) begin
         w_state_nxt = ST_IDLE;
         w_idx_nxt   = '0;
         w_rep_dec   = 1'b0;
         w_gap_load  = 1'b0;
         w_gap_dec   = 1'b0;
      end
`endif
      w_x_nxt = (w_state_nxt == ST_SEND) ? PATTERN[IDX_LAST - w_idx_nxt] : 1'b0;
   end

   assign x_out = r_x_out;
   assign valid = r_valid;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: per-cycle comparison against a burst-level expected-output queue, plus directed literals.
module tb_pattern_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] count = '0;
   logic [3:0] gap = '0;
   logic       x_out, valid, busy, done;
`ifdef PATTERN_TX_ABORT_EN
   logic       abort = 1'b0;
`endif

   always #5 clk = ~clk;

   pattern_tx dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .count (count),
      .gap   (gap),
      .x_out (x_out),
      .valid (valid),
      .busy  (busy),
`ifdef PATTERN_TX_ABORT_EN
      .done  (done),
      .abort (abort)
`else
      .done  (done)
`endif
   );

   int         n_chk  = 0;
   int         n_fail = 0;
   int         n_done = 0;
   logic [3:0] exp_q[$];
   logic [3:0] e_cur;
   logic       last_active = 1'b0;
   logic [3:0] pat_v = 4'b1011;
   logic [3:0] cap[0:31];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {x_out, valid, busy, done} for every cycle of a burst, then the mandatory IDLE cycle.
   task automatic model_accept(input int c, input int g);
      if (c == 0) begin
         exp_q.push_back(4'b0011);
      end else begin
         for (int r = 0; r < c; r++) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back({pat_v[b], 3'b110});
            if (r < c - 1)
               for (int z = 0; z < g; z++) exp_q.push_back(4'b0010);
         end
         exp_q.push_back(4'b0011);
      end
      exp_q.push_back(4'b0000);
   endtask

   always @(posedge clk or negedge rst) begin : model
      bit ab;
      if (!rst) begin
         exp_q.delete();
         last_active = 1'b0;
      end else begin
         ab = 1'b0;
`ifdef PATTERN_TX_ABORT_EN
         ab = abort;
`endif
         if (ab && last_active) exp_q.delete();
         else if ((exp_q.size() == 0) && start) model_accept(int'(count), int'(gap));
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         e_cur = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
         chk("stream", 32'({x_out, valid, busy, done}), 32'(e_cur));
         last_active = e_cur[1] & ~e_cur[0];
         if (done) n_done++;
      end
   end

   task automatic capture(input int c, input int g, input int n, input bit pulse);
      @(negedge clk);
      start = 1'b1;
      count = 8'(c);
      gap   = 4'(g);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         cap[k] = {x_out, valid, busy, done};
         start  = pulse && (k <= 6);
         count  = 8'($urandom);
         gap    = 4'($urandom);
      end
      start = 1'b0;
   endtask

   task automatic settle();
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!busy && (exp_q.size() == 0)) break;
         @(negedge clk);
         #1;
      end
      chk("settle_timeout", 32'({busy, exp_q.size() != 0}), 32'(0));
   endtask

   logic [3:0] lit1[0:5] = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0011, 4'b0000};

   initial begin
      int hits, nv, nd, d0;
      logic [3:0] sh;
      #1;
      chk("reset_outs", 32'({x_out, valid, busy, done}), 32'(0));
      @(negedge clk);
      #2 rst = 1'b1;

      capture(1, 0, 6, 1'b0);
      for (int k = 1; k <= 6; k++) chk("c1_cycle", 32'(cap[k]), 32'(lit1[k-1]));
      settle();

      capture(3, 2, 18, 1'b0);
      hits = 0;
      sh   = '0;
      for (int k = 1; k <= 17; k++) begin
         sh = {sh[2:0], cap[k][3]};
         if (sh == 4'b1011) hits++;
      end
      chk("c3_det_hits", 32'(hits), 32'(3));
      chk("c3_gap", 32'(cap[5]), 32'(4'b0010));
      chk("c3_last_bit", 32'(cap[16]), 32'(4'b1110));
      chk("c3_done", 32'(cap[17]), 32'(4'b0011));
      chk("c3_idle", 32'(cap[18]), 32'(0));
      settle();

      capture(2, 0, 12, 1'b1);
      nv = 0;
      nd = 0;
      sh = '0;
      for (int k = 1; k <= 12; k++) begin
         nv += int'(cap[k][2]);
         nd += int'(cap[k][0]);
      end
      for (int k = 5; k <= 8; k++) sh = {sh[2:0], cap[k][3]};
      chk("c2_valid_cnt", 32'(nv), 32'(8));
      chk("c2_done_cnt", 32'(nd), 32'(1));
      chk("c2_second_pat", 32'(sh), 32'(4'b1011));
      chk("c2_done_cyc", 32'(cap[9]), 32'(4'b0011));
      settle();

      capture(0, 3, 3, 1'b0);
      chk("c0_done", 32'(cap[1]), 32'(4'b0011));
      chk("c0_idle", 32'(cap[2]), 32'(0));
      settle();

      @(negedge clk);
      start = 1'b1;
      count = 8'd3;
      gap   = 4'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst", 32'({x_out, valid, busy, done}), 32'(0));
      d0 = n_done;
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_no_done", 32'(n_done - d0), 32'(0));
      chk("rst_idle_busy", 32'(busy), 32'(0));

`ifdef PATTERN_TX_ABORT_EN
      d0 = n_done;
      @(negedge clk);
      start = 1'b1;
      count = 8'd4;
      gap   = 4'd0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         cap[k] = {x_out, valid, busy, done};
         abort  = (k == 6);
         start  = (k == 7);
      end
      start = 1'b0;
      abort = 1'b0;
      chk("ab_cycle6", 32'(cap[6]), 32'(4'b0110));
      chk("ab_idle", 32'(cap[7]), 32'(0));
      chk("ab_restart", 32'(cap[8]), 32'(4'b1110));
      settle();
      chk("ab_done_cnt", 32'(n_done - d0), 32'(1));
`endif

      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         count = 8'($urandom_range(0, 4));
         gap   = 4'($urandom_range(0, 3));
`ifdef PATTERN_TX_ABORT_EN
         abort = ($urandom_range(0, 29) == 0);
`endif
      end
`ifdef PATTERN_TX_ABORT_EN
      abort = 1'b0;
`endif
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
